// File: rtl/unified_mem_responder.sv
// unified_mem_responder
// Single-port RAM shared by an instruction-fetch port and a data port.
// One access per transaction, sequenced by an IDLE/WAIT/RESP FSM with a
// configurable number of wait states. The data port has fixed priority.
// Ready strobes, load/fetch results and the error flag are registered and
// appear in the cycle after RESP.
//
// Build option:
//   MEM_ALIGN_CHECK_EN  - when defined, a data access whose byte address is
//                         not word aligned completes with d_err=1, its store
//                         is dropped and a load returns 0. When undefined the
//                         low two address bits are ignored and d_err stays 0.
module unified_mem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] pc,
  output logic [31:0] instr,
  output logic        i_ready,
  input  logic        d_req,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        d_ready,
  output logic        d_err
);

  localparam int AW = $clog2(DEPTH);
  // Final count value of the WAIT state; unused when there are no wait states.
  localparam logic [3:0] WS_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            we_q, we_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            sel_data_q, sel_data_d;
  logic            bad_q, bad_d;
  logic [31:0]     instr_q, instr_d;
  logic [31:0]     readdata_q, readdata_d;
  logic            i_ready_q, i_ready_d;
  logic            d_ready_q, d_ready_d;
  logic            d_err_q, d_err_d;

  logic [31:0]     mem_q [DEPTH];
  logic [31:0]     rd_word_s;
  logic            misalign_s;
  logic            unused_s;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_s = (dataadr[1:0] != 2'b00);
`else
  assign misalign_s = 1'b0;
`endif

  // Address bits outside the word index never influence the access.
  assign unused_s  = ^{pc[31:AW+2], pc[1:0], dataadr[31:AW+2], dataadr[1:0]};

  assign rd_word_s = mem_q[idx_q];

  // Next-state, transaction capture and response generation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    sel_data_d = sel_data_q;
    bad_d      = bad_q;
    instr_d    = instr_q;
    readdata_d = readdata_q;
    i_ready_d  = 1'b0;
    d_ready_d  = 1'b0;
    d_err_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = 4'd0;
        if (d_req) begin
          // Data wins over a simultaneous fetch.
          idx_d      = dataadr[AW+1:2];
          we_d       = memwrite;
          wdata_d    = writedata;
          sel_data_d = 1'b1;
          bad_d      = misalign_s;
          state_d    = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
        end else if (i_req) begin
          idx_d      = pc[AW+1:2];
          we_d       = 1'b0;
          wdata_d    = 32'h0000_0000;
          sel_data_d = 1'b0;
          bad_d      = 1'b0;
          state_d    = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
        end else begin
          state_d    = ST_IDLE;
        end
      end

      ST_WAIT: begin
        if (cnt_q == WS_LAST) begin
          cnt_d   = 4'd0;
          state_d = ST_RESP;
        end else begin
          cnt_d   = cnt_q + 4'd1;
          state_d = ST_WAIT;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
        if (sel_data_q) begin
          d_ready_d = 1'b1;
          d_err_d   = bad_q;
          if (we_q) begin
            // Stores leave the last load result in place.
            readdata_d = readdata_q;
          end else if (bad_q) begin
            readdata_d = 32'h0000_0000;
          end else begin
            readdata_d = rd_word_s;
          end
        end else begin
          i_ready_d = 1'b1;
          instr_d   = rd_word_s;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // FSM, latched transaction and registered outputs; reset aborts any transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      idx_q      <= '0;
      we_q       <= 1'b0;
      wdata_q    <= 32'h0000_0000;
      sel_data_q <= 1'b0;
      bad_q      <= 1'b0;
      instr_q    <= 32'h0000_0000;
      readdata_q <= 32'h0000_0000;
      i_ready_q  <= 1'b0;
      d_ready_q  <= 1'b0;
      d_err_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      sel_data_q <= sel_data_d;
      bad_q      <= bad_d;
      instr_q    <= instr_d;
      readdata_q <= readdata_d;
      i_ready_q  <= i_ready_d;
      d_ready_q  <= d_ready_d;
      d_err_q    <= d_err_d;
    end
  end

  // RAM store commits on the edge that ends RESP; contents survive reset.
  always_ff @(posedge clk) begin
    if ((state_q == ST_RESP) && sel_data_q && we_q && !bad_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign instr    = instr_q;
  assign readdata = readdata_q;
  assign i_ready  = i_ready_q;
  assign d_ready  = d_ready_q;
  assign d_err    = d_err_q;

endmodule

// File: tb/tb_unified_mem_responder.sv
// Self-checking bench for unified_mem_responder: table vectors, directed
// multi-cycle sequences and random traffic against a word-array model.
module tb_unified_mem_responder;

  localparam int DEPTH = 64;
  localparam int WS    = 1;
  localparam int LAT   = WS + 2;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, memwrite;
  logic [31:0] pc, dataadr, writedata;
  logic [31:0] instr, readdata;
  logic        i_ready, d_ready, d_err;

  logic        z_i_req, z_d_req, z_memwrite;
  logic [31:0] z_pc, z_dataadr, z_writedata;
  logic [31:0] z_instr, z_readdata;
  logic        z_i_ready, z_d_ready, z_d_err;

  always #5 clk = ~clk;

  unified_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS)) u_dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .pc(pc), .instr(instr), .i_ready(i_ready),
    .d_req(d_req), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .readdata(readdata), .d_ready(d_ready), .d_err(d_err)
  );

  unified_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .i_req(z_i_req), .pc(z_pc), .instr(z_instr), .i_ready(z_i_ready),
    .d_req(z_d_req), .memwrite(z_memwrite), .dataadr(z_dataadr),
    .writedata(z_writedata), .readdata(z_readdata), .d_ready(z_d_ready), .d_err(z_d_err)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: plain word array plus the last value seen on each port.
  logic [31:0] mm [DEPTH];
  logic [31:0] exp_instr, exp_rdata;
  logic        exp_err;

  typedef struct {
    bit          is_data;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] ev;
    bit          ee;
    string       nm;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic model_apply(input bit is_data, input bit we, input logic [31:0] addr,
                             input logic [31:0] wd);
    int idx;
    bit mis;
    idx = int'((addr / 32'd4) % DEPTH);
    mis = ALIGN && ((addr % 32'd4) != 32'd0);
    exp_err = is_data && mis;
    if (!is_data) exp_instr = mm[idx];
    else if (mis) begin
      if (!we) exp_rdata = 32'h0;
    end
    else if (we) mm[idx] = wd;
    else exp_rdata = mm[idx];
  endtask

  // Issue one transaction on the WS=1 instance and wait for its ready strobe.
  task automatic do_txn(input bit is_data, input bit we, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat, output logic [31:0] gi,
                        output logic [31:0] gr, output logic ge);
    bit other;
    lat = -1; other = 1'b0; gi = 'x; gr = 'x; ge = 1'bx;
    if (is_data) begin
      d_req = 1'b1; memwrite = we; dataadr = addr; writedata = wd; i_req = 1'b0;
    end else begin
      i_req = 1'b1; pc = addr; d_req = 1'b0;
    end
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        // Transaction is latched; input changes must not matter now.
        if (is_data) begin
          dataadr = $urandom; writedata = $urandom; memwrite = ~we;
        end else begin
          pc = $urandom;
        end
      end
      if (is_data ? i_ready : d_ready) other = 1'b1;
      if (is_data ? d_ready : i_ready) begin
        lat = k; gi = instr; gr = readdata; ge = d_err;
        break;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    chk("other_port_quiet", 32'(other), 32'd0);
  endtask

  task automatic run_check(input string nm, input bit is_data, input bit we,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] gi, output logic [31:0] gr,
                           output logic ge);
    int lat;
    do_txn(is_data, we, addr, wd, lat, gi, gr, ge);
    model_apply(is_data, we, addr, wd);
    chk({nm, "_lat"}, 32'(lat), 32'(LAT));
    chk({nm, "_err"}, 32'(ge), 32'(exp_err));
    chk({nm, "_instr"}, gi, exp_instr);
    chk({nm, "_rdata"}, gr, exp_rdata);
  endtask

  task automatic add_vec(input bit is_data, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] ev, input bit ee,
                         input string nm);
    vec_t v;
    v.is_data = is_data; v.we = we; v.addr = addr; v.wd = wd;
    v.ev = ev; v.ee = ee; v.nm = nm;
    tv.push_back(v);
  endtask

  // WS=0 instance: single store, expect ready in the cycle after RESP.
  task automatic zstore(input logic [31:0] addr, input logic [31:0] wd);
    int kz;
    kz = -1;
    z_d_req = 1'b1; z_memwrite = 1'b1; z_dataadr = addr; z_writedata = wd;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (z_d_ready) begin kz = k; break; end
    end
    z_d_req = 1'b0; z_memwrite = 1'b0;
    chk("ws0_store_lat", 32'(kz), 32'd2);
  endtask

  initial begin
    logic [31:0] gi, gr, old8, rv;
    logic        ge;
    int kd, ki, k1, k2, n;
    logic [31:0] g1, g2;

    reset = 1'b0;
    i_req = 1'b0; d_req = 1'b0; memwrite = 1'b0;
    pc = 32'h0; dataadr = 32'h0; writedata = 32'h0;
    z_i_req = 1'b0; z_d_req = 1'b0; z_memwrite = 1'b0;
    z_pc = 32'h0; z_dataadr = 32'h0; z_writedata = 32'h0;
    exp_instr = 32'h0; exp_rdata = 32'h0; exp_err = 1'b0;

    #12;
    chk("rst_instr", instr, 32'h0);
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_i_ready", 32'(i_ready), 32'd0);
    chk("rst_d_ready", 32'(d_ready), 32'd0);
    chk("rst_d_err", 32'(d_err), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Preload every word; random upper address bits exercise the wrap.
    for (int i = 0; i < DEPTH; i++) begin
      rv = $urandom;
      run_check("preload", 1'b1, 1'b1, {rv[31:8] , 8'(i * 4)}, $urandom, gi, gr, ge);
    end

    add_vec(1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, "st_10");
    add_vec(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, "ld_10");
    add_vec(1'b1, 1'b1, 32'h0000_0100, 32'h1234_5678, 32'h0, 1'b0, "st_100");
    add_vec(1'b1, 1'b0, 32'h0000_0000, 32'h0, 32'h1234_5678, 1'b0, "ld_0_wrap");
    add_vec(1'b0, 1'b0, 32'h0000_0000, 32'h0, 32'h1234_5678, 1'b0, "if_0");
    add_vec(1'b0, 1'b0, 32'h0000_0110, 32'h0, 32'hDEAD_BEEF, 1'b0, "if_110_wrap");
    add_vec(1'b1, 1'b1, 32'h0000_0020, 32'h1111_2222, 32'h0, 1'b0, "st_20");
    add_vec(1'b1, 1'b1, 32'h0000_0022, 32'h3333_4444, 32'h0, ALIGN, "st_22_mis");
    add_vec(1'b1, 1'b0, 32'h0000_0020, 32'h0,
            ALIGN ? 32'h1111_2222 : 32'h3333_4444, 1'b0, "ld_20");
    add_vec(1'b1, 1'b0, 32'h0000_0021, 32'h0,
            ALIGN ? 32'h0 : 32'h3333_4444, ALIGN, "ld_21_mis");
    add_vec(1'b0, 1'b0, 32'h0000_0022, 32'h0,
            ALIGN ? 32'h1111_2222 : 32'h3333_4444, 1'b0, "if_22_noalign");
    add_vec(1'b1, 1'b1, 32'h0000_00FC, 32'hCAFE_F00D, 32'h0, 1'b0, "st_fc");
    add_vec(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'hCAFE_F00D, 1'b0, "ld_top_wrap");

    foreach (tv[i]) begin
      run_check(tv[i].nm, tv[i].is_data, tv[i].we, tv[i].addr, tv[i].wd, gi, gr, ge);
      chk({tv[i].nm, "_tbl_err"}, 32'(ge), 32'(tv[i].ee));
      if (!(tv[i].is_data && tv[i].we))
        chk({tv[i].nm, "_tbl_val"}, tv[i].is_data ? gr : gi, tv[i].ev);
    end

    // Simultaneous requests: data first, fetch after one IDLE gap.
    kd = -1; ki = -1;
    i_req = 1'b1; pc = 32'h0; d_req = 1'b1; memwrite = 1'b0; dataadr = 32'h4;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (d_ready && kd < 0) begin
        kd = k;
        chk("both_instr_hold", instr, exp_instr);
        chk("both_rdata", readdata, mm[1]);
        d_req = 1'b0;
      end
      if (i_ready) begin
        ki = k;
        chk("both_instr", instr, mm[0]);
        chk("both_rdata_hold", readdata, mm[1]);
        i_req = 1'b0;
        break;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    chk("both_d_lat", 32'(kd), 32'(LAT));
    chk("both_i_lat", 32'(ki), 32'(2 * LAT));
    exp_rdata = mm[1]; exp_instr = mm[0];

    // Reset during WAIT aborts a store; RAM keeps its old word.
    old8 = mm[8];
    d_req = 1'b1; memwrite = 1'b1; dataadr = 32'h20; writedata = 32'hAAAA_5555;
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("abort_instr", instr, 32'h0);
    chk("abort_readdata", readdata, 32'h0);
    chk("abort_i_ready", 32'(i_ready), 32'd0);
    chk("abort_d_ready", 32'(d_ready), 32'd0);
    chk("abort_d_err", 32'(d_err), 32'd0);
    d_req = 1'b0; memwrite = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_hold_d_ready", 32'(d_ready), 32'd0);
    reset = 1'b1;
    exp_instr = 32'h0; exp_rdata = 32'h0;
    run_check("abort_reload", 1'b1, 1'b0, 32'h20, 32'h0, gi, gr, ge);
    chk("abort_keep_word", gr, old8);

    // Random traffic, mostly aligned.
    for (int i = 0; i < 150; i++) begin
      bit isd, wr;
      logic [31:0] a;
      isd = ($urandom_range(0, 2) != 0);
      wr  = ($urandom_range(0, 1) != 0);
      a   = $urandom;
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      run_check("rand", isd, isd && wr, a, $urandom, gi, gr, ge);
    end

    // WAIT_STATES=0 instance: back-to-back fetches.
    zstore(32'h0, 32'h0BAD_CAFE);
    zstore(32'h4, 32'h600D_F00D);
    k1 = -1; k2 = -1; n = 0; g1 = 'x; g2 = 'x;
    z_i_req = 1'b1; z_pc = 32'h0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (z_i_ready) begin
        if (n == 0) begin
          k1 = k; g1 = z_instr; z_pc = 32'h4;
        end else begin
          k2 = k; g2 = z_instr; z_i_req = 1'b0;
        end
        n++;
        if (n == 2) break;
      end
    end
    z_i_req = 1'b0;
    chk("ws0_if1_lat", 32'(k1), 32'd2);
    chk("ws0_if2_lat", 32'(k2), 32'd4);
    chk("ws0_if1_val", g1, 32'h0BAD_CAFE);
    chk("ws0_if2_val", g2, 32'h600D_F00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
